ula_arbiter: RTL and testbench

Sequencing and arbitration controller that shares a single `ula` instance between two requesters, such as the instruction datapath and a secondary unit. Each requester submits opcode and operands with a req/ack handshake. The arbiter grants one request at a time and registers the operands that drive the `ula` inputs. It captures `out`/`rflags` after one settle cycle and returns them with a one-cycle ack. It also keeps a saturating count of results that raised the ERROR flag.

---
 rtl/ula_arbiter.sv | 145 ++++++++++++++
 tb/tb_ula_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbiter.sv
// rtl/ula_arbiter.sv - two-requester arbiter sharing one ula; define ULA_ARB_RR_EN for round-robin, otherwise fixed priority (port 0 first)
module ula_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int OPCODE_WIDTH = 4,
  parameter int ERRCNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic                    req1,
  input  logic [OPCODE_WIDTH-1:0] opcode0,
  input  logic [OPCODE_WIDTH-1:0] opcode1,
  input  logic [DATA_WIDTH-1:0]   data1_0,
  input  logic [DATA_WIDTH-1:0]   data2_0,
  input  logic [DATA_WIDTH-1:0]   data1_1,
  input  logic [DATA_WIDTH-1:0]   data2_1,
  output logic                    ack0,
  output logic                    ack1,
  output logic [DATA_WIDTH-1:0]   out,
  output logic [4:0]              rflags,
  output logic                    busy,
  output logic                    grant,
  output logic [ERRCNT_WIDTH-1:0] err_count,
  output logic [OPCODE_WIDTH-1:0] ula_opcode,
  output logic [DATA_WIDTH-1:0]   ula_data1,
  output logic [DATA_WIDTH-1:0]   ula_data2,
  input  logic [DATA_WIDTH-1:0]   ula_out,
  input  logic [4:0]              ula_rflags
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_grant;
  logic [OPCODE_WIDTH-1:0] r_opcode;
  logic [DATA_WIDTH-1:0]   r_data1;
  logic [DATA_WIDTH-1:0]   r_data2;
  logic [DATA_WIDTH-1:0]   r_out;
  logic [4:0]              r_rflags;
  logic [ERRCNT_WIDTH-1:0] r_err_count;
  logic                    w_any;
  logic                    w_win;

  assign w_any = req0 | req1;

`ifdef ULA_ARB_RR_EN
  logic r_rr_ptr;

  // Round-robin pointer: after each completion it points at the port that was not served
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_rr_ptr <= ~r_grant;
    end
  end

  // Winner: a lone requester wins outright; contention is settled by the pointer
  always_comb begin
    w_win = ~req0;
    if (req0 && req1) begin
      w_win = r_rr_ptr;
    end
  end
`else
  // Winner: port 0 whenever it requests, port 1 only when port 0 is quiet
  always_comb begin
    w_win = ~req0;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus decoded handshake outputs; reset suppresses a pending ack
  always_comb begin
    w_next = r_state;
    ack0   = 1'b0;
    ack1   = 1'b0;
    busy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        ack0   = ~r_grant & ~rst;
        ack1   = r_grant & ~rst;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand capture at grant, result capture and error counting at the end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant     <= 1'b0;
      r_opcode    <= '0;
      r_data1     <= '0;
      r_data2     <= '0;
      r_out       <= '0;
      r_rflags    <= '0;
      r_err_count <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_grant  <= w_win;
        r_opcode <= w_win ? opcode1 : opcode0;
        r_data1  <= w_win ? data1_1 : data1_0;
        r_data2  <= w_win ? data2_1 : data2_0;
      end
      if (r_state == S_EXEC) begin
        r_out    <= ula_out;
        r_rflags <= ula_rflags;
        if (ula_rflags[0] && (r_err_count != {ERRCNT_WIDTH{1'b1}})) begin
          r_err_count <= r_err_count + {{(ERRCNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign grant      = r_grant;
  assign out        = r_out;
  assign rflags     = r_rflags;
  assign err_count  = r_err_count;
  assign ula_opcode = r_opcode;
  assign ula_data1  = r_data1;
  assign ula_data2  = r_data2;

endmodule

// File: tb/tb_ula_arbiter.sv
// tb/tb_ula_arbiter.sv - self-checking bench for ula_arbiter with a stand-in ula and a transaction-level model
module tb_ula_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_CMP = 4'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [3:0]  opcode0 = '0, opcode1 = '0;
  logic [15:0] data1_0 = '0, data2_0 = '0, data1_1 = '0, data2_1 = '0;
  logic        ack0, ack1, busy, grant;
  logic [15:0] out;
  logic [4:0]  rflags;
  logic [7:0]  err_count;
  logic [3:0]  ula_opcode;
  logic [15:0] ula_data1, ula_data2, ula_out;
  logic [4:0]  ula_rflags;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ula_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .opcode0(opcode0), .opcode1(opcode1),
    .data1_0(data1_0), .data2_0(data2_0), .data1_1(data1_1), .data2_1(data2_1),
    .ack0(ack0), .ack1(ack1), .out(out), .rflags(rflags), .busy(busy), .grant(grant),
    .err_count(err_count), .ula_opcode(ula_opcode), .ula_data1(ula_data1),
    .ula_data2(ula_data2), .ula_out(ula_out), .ula_rflags(ula_rflags)
  );

  // Stand-in ula: returns {OVERFLOW, ABOVE, EQUAL, BELOW, ERROR, out}
  function automatic logic [20:0] ula_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0]        r;
    logic               ovf, err, ab, eq, be;
    logic signed [31:0] p;
    logic signed [15:0] x, y;
    r = '0; ovf = 1'b0; err = 1'b0; p = '0;
    case (op)
      OP_ADD: begin r = a + b; ovf = (a[15] == b[15]) && (r[15] != a[15]); end
      OP_SUB: begin r = a - b; ovf = (a[15] != b[15]) && (r[15] != a[15]); end
      OP_MUL: begin p = $signed(a) * $signed(b); r = p[15:0]; ovf = (p > 32'sd32767) || (p < -32'sd32768); end
      OP_DIV: begin if (b == 16'd0) err = 1'b1; else r = 16'($signed(a) / $signed(b)); end
      OP_CMP: begin r = a - b; end
      default: err = 1'b1;
    endcase
    if (op == OP_CMP) begin x = $signed(a); y = $signed(b); end
    else begin x = $signed(r); y = 16'sd0; end
    ab = (x > y) && !err;
    eq = (x == y) && !err;
    be = (x < y) && !err;
    return {ovf, ab, eq, be, err, r};
  endfunction

  assign {ula_rflags, ula_out} = ula_fn(ula_opcode, ula_data1, ula_data2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction model: m_left counts cycles until the transaction retires (2 = operating, 1 = acking)
  int          m_left = 0;
  logic        m_grant = 1'b0;
  logic        m_turn = 1'b0;
  logic [3:0]  m_op = '0;
  logic [15:0] m_a = '0, m_b = '0, m_out = '0;
  logic [4:0]  m_fl = '0;
  logic [7:0]  m_err = '0;
  logic [20:0] m_res;
  logic        m_pick;

  assign m_res = ula_fn(m_op, m_a, m_b);
`ifdef ULA_ARB_RR_EN
  assign m_pick = (req0 && req1) ? m_turn : req1;
`else
  assign m_pick = req0 ? 1'b0 : 1'b1;
`endif

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_left <= 0; m_grant <= 1'b0; m_turn <= 1'b0; m_op <= '0; m_a <= '0; m_b <= '0;
      m_out <= '0; m_fl <= '0; m_err <= '0;
    end else if (m_left == 2) begin
      m_out  <= m_res[15:0];
      m_fl   <= m_res[20:16];
      m_err  <= (m_res[16] && m_err != 8'hFF) ? m_err + 8'd1 : m_err;
      m_left <= 1;
    end else if (m_left == 1) begin
      m_turn <= !m_grant;
      m_left <= 0;
    end else if (req0 || req1) begin
      m_grant <= m_pick;
      m_op    <= m_pick ? opcode1 : opcode0;
      m_a     <= m_pick ? data1_1 : data1_0;
      m_b     <= m_pick ? data2_1 : data2_0;
      m_left  <= 2;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack0", ack0, (m_left == 1) && !m_grant && !rst);
      chk("ack1", ack1, (m_left == 1) && m_grant && !rst);
      chk("busy", busy, m_left != 0);
      chk("grant", grant, m_grant);
      chk("out", out, m_out);
      chk("rflags", rflags, m_fl);
      chk("err_count", err_count, m_err);
      chk("ula_opcode", ula_opcode, m_op);
      chk("ula_data1", ula_data1, m_a);
      chk("ula_data2", ula_data2, m_b);
    end
  end

  task automatic wait_ack(input int port, output logic [15:0] ro, output logic [4:0] rf,
                          output int lat, output int nbusy, output int other);
    lat = -1; nbusy = 0; other = 0; ro = '0; rf = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if ((port == 0) ? ack1 : ack0) other++;
      if ((port == 0) ? ack0 : ack1) begin
        lat = k; ro = out; rf = rflags;
        break;
      end
    end
    @(posedge clk); #1;
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_timeout: port %0d got no ack within 12 cycles", port);
    end
  endtask

  task automatic run_op(input int port, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] ro, output logic [4:0] rf, output int lat,
                        output int nbusy, output int other);
    if (port == 0) begin opcode0 = op; data1_0 = a; data2_0 = b; req0 = 1'b1; end
    else begin opcode1 = op; data1_1 = a; data2_1 = b; req1 = 1'b1; end
    wait_ack(port, ro, rf, lat, nbusy, other);
  endtask

  logic [15:0] ro, o0, o1;
  logic [4:0]  rf;
  int          lat, nb, oth, t0, t1, n;
  int          gseq[6];

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_out", out, 16'd0);
    chk("reset_rflags", rflags, 5'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ula_data1", ula_data1, 16'd0);
    @(posedge clk); #1;

    // ADD 5+10 on port 0
    run_op(0, OP_ADD, 16'd5, 16'd10, ro, rf, lat, nb, oth);
    chk("add_out", ro, 16'd15);
    chk("add_flags", rf, 5'b01000);
    chk("add_latency", lat, 2);
    chk("add_busy_cycles", nb, 2);
    chk("add_ack1_quiet", oth, 0);

    // DIV 6/0 on port 1, then saturate the error counter
    run_op(1, OP_DIV, 16'd6, 16'd0, ro, rf, lat, nb, oth);
    chk("div0_flags", rf, 5'b00001);
    chk("div0_errcnt", err_count, 8'd1);
    for (int i = 0; i < 300; i++) begin
      run_op(1, OP_DIV, 16'd7, 16'd0, ro, rf, lat, nb, oth);
      if (i == 252) chk("errcnt_254", err_count, 8'd254);
      if (i == 253) chk("errcnt_255", err_count, 8'd255);
    end
    chk("errcnt_saturated", err_count, 8'd255);

    // Simultaneous SUB 5-3 on port 0 and MUL 5*2 on port 1
    opcode0 = OP_SUB; data1_0 = 16'd5; data2_0 = 16'd3;
    opcode1 = OP_MUL; data1_1 = 16'd5; data2_1 = 16'd2;
    req0 = 1'b1; req1 = 1'b1;
    t0 = -1; t1 = -1; o0 = '0; o1 = '0;
    for (int k = 0; k < 20 && t1 < 0; k++) begin
      @(negedge clk);
      if (ack0 && t0 < 0) begin t0 = cyc; o0 = out; @(posedge clk); #1 req0 = 1'b0; end
      else if (ack1) begin t1 = cyc; o1 = out; @(posedge clk); #1 req1 = 1'b0; end
    end
    chk("sim_out0", o0, 16'd2);
    chk("sim_out1", o1, 16'd10);
    chk("sim_ack0_seen", t0 >= 0, 1'b1);
    chk("sim_gap", t1 - t0, 3);

    // Both ports requesting continuously for six completions
    opcode0 = OP_ADD; data1_0 = 16'd1; data2_0 = 16'd2;
    opcode1 = OP_ADD; data1_1 = 16'd3; data2_1 = 16'd4;
    req0 = 1'b1; req1 = 1'b1;
    n = 0;
    for (int k = 0; k < 60 && n < 6; k++) begin
      @(negedge clk);
      if (ack0 || ack1) begin gseq[n] = int'(grant); n++; end
    end
    @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
    chk("cont_count", n, 6);
    for (int i = 0; i < 6; i++) begin
`ifdef ULA_ARB_RR_EN
      chk($sformatf("cont_grant%0d", i), gseq[i], i % 2);
`else
      chk($sformatf("cont_grant%0d", i), gseq[i], 0);
`endif
    end

    // CMP -5 vs 8 on port 0, data1 changed after grant
    opcode0 = OP_CMP; data1_0 = 16'hFFFB; data2_0 = 16'd8; req0 = 1'b1;
    @(posedge clk); #1 data1_0 = 16'd100;
    wait_ack(0, ro, rf, lat, nb, oth);
    chk("cmp_out", ro, 16'hFFF3);
    chk("cmp_flags", rf, 5'b00010);

    // Reset during EXEC of ADD 32767+1
    opcode0 = OP_ADD; data1_0 = 16'h7FFF; data2_0 = 16'd1; req0 = 1'b1;
    @(posedge clk); #1 rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    chk("rst_exec_busy", busy, 1'b1);
    chk("rst_exec_noack", ack0 | ack1, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ack", {ack0, ack1}, 2'b00);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_out", out, 16'd0);
    chk("post_rst_rflags", rflags, 5'd0);
    chk("post_rst_errcnt", err_count, 8'd0);
    chk("post_rst_ula", {ula_opcode, ula_data1, ula_data2}, 36'd0);
    @(posedge clk); #1;
    run_op(1, OP_ADD, 16'd5, 16'hFFFB, ro, rf, lat, nb, oth);
    chk("zero_out", ro, 16'd0);
    chk("zero_flags", rf, 5'b00100);
    chk("zero_latency", lat, 2);
    chk("zero_ack0_quiet", oth, 0);

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
